// File: rtl/decode.sv
// Decode/register-read stage: latches op/operands on STATE_ID, commits write-back on STATE_WB; one-cycle latency, no backpressure.
// Optional sticky illegal-instruction flag enabled by defining DECODE_ILLEGAL_EN.
module decode #(
   parameter int DATA_W   = 32,
   parameter int RETIRE_W = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [2:0]          state,
   input  logic [31:0]         instruction,
   input  logic                wb_en,
   input  logic [4:0]          wb_addr,
   input  logic [DATA_W-1:0]   wb_data,
   output logic [1:0]          op,
   output logic [DATA_W-1:0]   src1,
   output logic [DATA_W-1:0]   src2,
   output logic [4:0]          dest,
   output logic                illegal,
   output logic [RETIRE_W-1:0] retired
);

   // Encodings shared with state_defs.v of the processor.
   localparam logic [2:0] STATE_ID = 3'd1;
   localparam logic [2:0] STATE_WB = 3'd4;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_ADDIU = 2'd1;
   localparam logic [1:0] OP_ADDU  = 2'd2;
   localparam logic [1:0] OP_SUBU  = 2'd3;

   logic [5:0]  opcode;
   logic [4:0]  rs, rt, rd;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [4:0]  unused_shamt;

   assign opcode       = instruction[31:26];
   assign rs           = instruction[25:21];
   assign rt           = instruction[20:16];
   assign rd           = instruction[15:11];
   assign unused_shamt = instruction[10:6];
   assign funct        = instruction[5:0];
   assign imm16        = instruction[15:0];

   logic [DATA_W-1:0]   regs_q [32];
   logic [DATA_W-1:0]   regs_d [32];
   logic [1:0]          op_q, op_d;
   logic [DATA_W-1:0]   src1_q, src1_d;
   logic [DATA_W-1:0]   src2_q, src2_d;
   logic [4:0]          dest_q, dest_d;
   logic [RETIRE_W-1:0] retired_q, retired_d;
   logic [DATA_W-1:0]   rs_val, rt_val;
   logic                is_nop;

   assign rs_val = (rs == 5'd0) ? '0 : regs_q[rs];
   assign rt_val = (rt == 5'd0) ? '0 : regs_q[rt];

   always_comb begin
      op_d      = op_q;
      src1_d    = src1_q;
      src2_d    = src2_q;
      dest_d    = dest_q;
      retired_d = retired_q;
      regs_d    = regs_q;
      is_nop    = 1'b0;

      if (state == STATE_ID) begin
         op_d   = OP_NOP;
         src1_d = '0;
         src2_d = '0;
         dest_d = '0;
         if (opcode == 6'b001001) begin
            op_d   = OP_ADDIU;
            src1_d = rs_val;
            src2_d = {{(DATA_W-16){imm16[15]}}, imm16};
            dest_d = rt;
         end else if (opcode == 6'b000000 && funct == 6'b100001) begin
            op_d   = OP_ADDU;
            src1_d = rs_val;
            src2_d = rt_val;
            dest_d = rd;
         end else if (opcode == 6'b000000 && funct == 6'b100011) begin
            op_d   = OP_SUBU;
            src1_d = rs_val;
            src2_d = rt_val;
            dest_d = rd;
         end else begin
            is_nop = 1'b1;
         end
      end

      // Writes to reg 0 are dropped but still count as retired.
      if (state == STATE_WB && wb_en) begin
         if (wb_addr != 5'd0) begin
            regs_d[wb_addr] = wb_data;
         end
         retired_d = retired_q + RETIRE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= OP_NOP;
         src1_q    <= '0;
         src2_q    <= '0;
         dest_q    <= '0;
         retired_q <= '0;
         regs_q    <= '{default: '0};
      end else begin
         op_q      <= op_d;
         src1_q    <= src1_d;
         src2_q    <= src2_d;
         dest_q    <= dest_d;
         retired_q <= retired_d;
         regs_q    <= regs_d;
      end
   end

`ifdef DECODE_ILLEGAL_EN
   logic illegal_q, illegal_d;

   // All-zero word is the canonical NOP and never flags.
   always_comb begin
      illegal_d = illegal_q | (is_nop && instruction != 32'h0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end

   assign illegal = illegal_q;
`else
   logic unused_is_nop;
   assign unused_is_nop = is_nop;
   assign illegal       = 1'b0;
`endif

   assign op      = op_q;
   assign src1    = src1_q;
   assign src2    = src2_q;
   assign dest    = dest_q;
   assign retired = retired_q;

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for decode.
module tb_decode;

   localparam logic [2:0] STATE_IF = 3'd0;
   localparam logic [2:0] STATE_ID = 3'd1;
   localparam logic [2:0] STATE_EX = 3'd2;
   localparam logic [2:0] STATE_WB = 3'd4;

   logic        clk;
   logic        rst_n;
   logic [2:0]  state;
   logic [31:0] instruction;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic [1:0]  op;
   logic [31:0] src1, src2;
   logic [4:0]  dest;
   logic        illegal;
   logic [7:0]  retired;

   int errors = 0;
   int checks = 0;

   decode #(.DATA_W(32), .RETIRE_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .state(state), .instruction(instruction),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
      .op(op), .src1(src1), .src2(src2), .dest(dest),
      .illegal(illegal), .retired(retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
   task automatic step(input logic [2:0] st, input logic [31:0] ins, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd);
      state = st; instruction = ins; wb_en = we; wb_addr = wa; wb_data = wd;
      @(posedge clk);
      @(negedge clk);
      state = STATE_IF; wb_en = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (op !== 2'd0)        begin errors++; $display("FAIL reset_op got %h want 0", op); end
      checks++; if (src1 !== 32'h0)     begin errors++; $display("FAIL reset_src1 got %h want 0", src1); end
      checks++; if (src2 !== 32'h0)     begin errors++; $display("FAIL reset_src2 got %h want 0", src2); end
      checks++; if (dest !== 5'd0)      begin errors++; $display("FAIL reset_dest got %h want 0", dest); end
      checks++; if (illegal !== 1'b0)   begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
      checks++; if (retired !== 8'd0)   begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_addiu();
      step(STATE_ID, 32'h2401002D, 1'b0, 5'd0, 32'h0);
      checks++; if (op !== 2'd1)          begin errors++; $display("FAIL addiu_op got %0d want 1", op); end
      checks++; if (src1 !== 32'h0)       begin errors++; $display("FAIL addiu_src1 got %h want 0", src1); end
      checks++; if (src2 !== 32'h0000002D) begin errors++; $display("FAIL addiu_src2 got %h want 0000002d", src2); end
      checks++; if (dest !== 5'd1)        begin errors++; $display("FAIL addiu_dest got %0d want 1", dest); end
   endtask

   task automatic test_sign_ext();
      step(STATE_ID, 32'h2403FFC4, 1'b0, 5'd0, 32'h0);
      checks++; if (op !== 2'd1)          begin errors++; $display("FAIL sext_op got %0d want 1", op); end
      checks++; if (src2 !== 32'hFFFFFFC4) begin errors++; $display("FAIL sext_src2 got %h want ffffffc4", src2); end
      checks++; if (dest !== 5'd3)        begin errors++; $display("FAIL sext_dest got %0d want 3", dest); end
   endtask

   task automatic test_hold();
      step(STATE_EX, 32'h00222821, 1'b0, 5'd0, 32'h0);
      step(3'd7, 32'h00413023, 1'b0, 5'd0, 32'h0);
      checks++; if (op !== 2'd1)          begin errors++; $display("FAIL hold_op got %0d want 1", op); end
      checks++; if (src2 !== 32'hFFFFFFC4) begin errors++; $display("FAIL hold_src2 got %h want ffffffc4", src2); end
      checks++; if (dest !== 5'd3)        begin errors++; $display("FAIL hold_dest got %0d want 3", dest); end
   endtask

   task automatic test_wb_rtype();
      step(STATE_WB, 32'h0, 1'b1, 5'd1, 32'd45);
      step(STATE_WB, 32'h0, 1'b1, 5'd2, 32'd7);
      checks++; if (retired !== 8'd2)     begin errors++; $display("FAIL wb_retired got %0d want 2", retired); end
      step(STATE_ID, 32'h00222821, 1'b0, 5'd0, 32'h0);
      checks++; if (op !== 2'd2)          begin errors++; $display("FAIL addu_op got %0d want 2", op); end
      checks++; if (src1 !== 32'd45)      begin errors++; $display("FAIL addu_src1 got %0d want 45", src1); end
      checks++; if (src2 !== 32'd7)       begin errors++; $display("FAIL addu_src2 got %0d want 7", src2); end
      checks++; if (dest !== 5'd5)        begin errors++; $display("FAIL addu_dest got %0d want 5", dest); end
      // SUBU $6,$2,$1
      step(STATE_ID, 32'h00413023, 1'b0, 5'd0, 32'h0);
      checks++; if (op !== 2'd3)          begin errors++; $display("FAIL subu_op got %0d want 3", op); end
      checks++; if (src1 !== 32'd7)       begin errors++; $display("FAIL subu_src1 got %0d want 7", src1); end
      checks++; if (src2 !== 32'd45)      begin errors++; $display("FAIL subu_src2 got %0d want 45", src2); end
      checks++; if (dest !== 5'd6)        begin errors++; $display("FAIL subu_dest got %0d want 6", dest); end
      // ADDIU $8,$1,-1 reads reg1 through the immediate path
      step(STATE_ID, 32'h2428FFFF, 1'b0, 5'd0, 32'h0);
      checks++; if (src1 !== 32'd45)      begin errors++; $display("FAIL addiu_rs_src1 got %0d want 45", src1); end
   endtask

   task automatic test_reg0_offstate();
      step(STATE_WB, 32'h0, 1'b1, 5'd0, 32'd99);
      checks++; if (retired !== 8'd3)     begin errors++; $display("FAIL reg0_retired got %0d want 3", retired); end
      step(STATE_ID, 32'h00222821, 1'b1, 5'd4, 32'd55);
      step(3'd7, 32'h0, 1'b1, 5'd4, 32'd66);
      step(STATE_EX, 32'h0, 1'b1, 5'd4, 32'd77);
      checks++; if (retired !== 8'd3)     begin errors++; $display("FAIL offstate_retired got %0d want 3", retired); end
      // ADDU $7,$0,$4
      step(STATE_ID, 32'h00043821, 1'b0, 5'd0, 32'h0);
      checks++; if (src1 !== 32'h0)       begin errors++; $display("FAIL reg0_src1 got %h want 0", src1); end
      checks++; if (src2 !== 32'h0)       begin errors++; $display("FAIL reg4_src2 got %h want 0", src2); end
      checks++; if (dest !== 5'd7)        begin errors++; $display("FAIL reg4_dest got %0d want 7", dest); end
   endtask

   task automatic test_illegal();
      step(STATE_ID, 32'h00000000, 1'b0, 5'd0, 32'h0);
      checks++; if (illegal !== 1'b0)     begin errors++; $display("FAIL zero_word_illegal got %b want 0", illegal); end
      checks++; if (op !== 2'd0)          begin errors++; $display("FAIL zero_word_op got %0d want 0", op); end
      step(STATE_ID, 32'hFC000000, 1'b0, 5'd0, 32'h0);
      checks++; if (op !== 2'd0)          begin errors++; $display("FAIL nop_op got %0d want 0", op); end
      checks++; if (src1 !== 32'h0 || src2 !== 32'h0 || dest !== 5'd0)
         begin errors++; $display("FAIL nop_fields got %h %h %0d want 0 0 0", src1, src2, dest); end
`ifdef DECODE_ILLEGAL_EN
      checks++; if (illegal !== 1'b1)     begin errors++; $display("FAIL illegal_set got %b want 1", illegal); end
`else
      checks++; if (illegal !== 1'b0)     begin errors++; $display("FAIL illegal_off got %b want 0", illegal); end
`endif
      // ADD (funct 100000) is unsupported and must decode as NOP.
      step(STATE_ID, 32'h00222820, 1'b0, 5'd0, 32'h0);
      checks++; if (op !== 2'd0 || src1 !== 32'h0 || dest !== 5'd0)
         begin errors++; $display("FAIL add_nop got op=%0d src1=%h dest=%0d want 0 0 0", op, src1, dest); end
      step(STATE_ID, 32'h2401002D, 1'b0, 5'd0, 32'h0);
      checks++; if (op !== 2'd1)          begin errors++; $display("FAIL after_illegal_op got %0d want 1", op); end
`ifdef DECODE_ILLEGAL_EN
      checks++; if (illegal !== 1'b1)     begin errors++; $display("FAIL illegal_sticky got %b want 1", illegal); end
`else
      checks++; if (illegal !== 1'b0)     begin errors++; $display("FAIL illegal_off_after got %b want 0", illegal); end
`endif
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 252; i++) step(STATE_WB, 32'h0, 1'b1, 5'd9, i);
      checks++; if (retired !== 8'd255)   begin errors++; $display("FAIL retired_max got %0d want 255", retired); end
      step(STATE_WB, 32'h0, 1'b1, 5'd9, 32'h0);
      checks++; if (retired !== 8'd0)     begin errors++; $display("FAIL retired_wrap got %0d want 0", retired); end
   endtask

   task automatic test_reset_mid();
      step(STATE_WB, 32'h0, 1'b1, 5'd1, 32'h1234);
      checks++; if (retired !== 8'd1)     begin errors++; $display("FAIL pre_reset_retired got %0d want 1", retired); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (op !== 2'd0 || src1 !== 32'h0 || src2 !== 32'h0 || dest !== 5'd0)
         begin errors++; $display("FAIL midreset_outs got %0d %h %h %0d want 0 0 0 0", op, src1, src2, dest); end
      checks++; if (retired !== 8'd0)     begin errors++; $display("FAIL midreset_retired got %0d want 0", retired); end
      checks++; if (illegal !== 1'b0)     begin errors++; $display("FAIL midreset_illegal got %b want 0", illegal); end
      @(negedge clk);
      rst_n = 1'b1;
      step(STATE_ID, 32'h00222821, 1'b0, 5'd0, 32'h0);
      checks++; if (op !== 2'd2)          begin errors++; $display("FAIL postreset_op got %0d want 2", op); end
      checks++; if (src1 !== 32'h0)       begin errors++; $display("FAIL postreset_reg1 got %h want 0", src1); end
      checks++; if (src2 !== 32'h0)       begin errors++; $display("FAIL postreset_reg2 got %h want 0", src2); end
   endtask

   initial begin
      rst_n = 1'b0; state = STATE_IF; instruction = 32'h0;
      wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
      test_reset();
      test_addiu();
      test_sign_ext();
      test_hold();
      test_wb_rtype();
      test_reg0_offstate();
      test_illegal();
      test_wrap();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
